// File: rtl/ysyx_22041071_id_issue_stage.sv
// Decode/issue stage: 2R1W register file, N-source operand forwarding,
// load-use stall detection and a valid/ready output pipeline register.
// Optional feature macro: YSYX_22041071_RF_DUMP_EN adds the flat rf_dump
// output carrying the registered register-file contents.
module ysyx_22041071_id_issue_stage #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NFWD   = 3,
    parameter int CTRL_W = 8,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_ins,
    input  logic [RAW-1:0]         rs1,
    input  logic [RAW-1:0]         rs2,
    input  logic [RAW-1:0]         rd,
    input  logic                   rs1_used,
    input  logic                   rs2_used,
    input  logic [XLEN-1:0]        imm,
    input  logic [1:0]             src1_sel,
    input  logic [1:0]             src2_sel,
    input  logic                   rd_we,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*RAW-1:0]    fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   fwd_is_load,
    input  logic                   wb_en,
    input  logic [RAW-1:0]         wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_ins,
    output logic [XLEN-1:0]        out_src_a,
    output logic [XLEN-1:0]        out_src_b,
    output logic [XLEN-1:0]        out_rs2_data,
    output logic [RAW-1:0]         out_rd,
    output logic                   out_rd_we,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [31:0]            stall_cnt
`ifdef YSYX_22041071_RF_DUMP_EN
    ,
    output logic [NREG*XLEN-1:0]   rf_dump
`endif
);

    logic [XLEN-1:0] rf_reg [NREG];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] src_a_next;
    logic [XLEN-1:0] src_b_next;
    logic [RAW-1:0]  rd0;
    logic            hz;
    logic            advance;

    // Youngest matching forward source wins, then the same-cycle write-back,
    // then the register file. x0 never matches anything and reads zero.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RAW-1:0]       rs,
        input logic [XLEN-1:0]      rf_val,
        input logic [NFWD-1:0]      fv,
        input logic [NFWD*RAW-1:0]  frd,
        input logic [NFWD*XLEN-1:0] fdat,
        input logic                 we,
        input logic [RAW-1:0]       wrd,
        input logic [XLEN-1:0]      wdat
    );
        logic [XLEN-1:0] v;
        logic            hit;
        v   = rf_val;
        hit = 1'b0;
        if (we && wrd == rs) v = wdat;
        for (int i = 0; i < NFWD; i++) begin
            if (!hit && fv[i] && frd[i*RAW +: RAW] == rs) begin
                v   = fdat[i*XLEN +: XLEN];
                hit = 1'b1;
            end
        end
        if (rs == '0) v = '0;
        return v;
    endfunction

    // Register file: whole array cleared on reset, x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) rf_reg[k] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            rf_reg[wb_rd] <= wb_data;
        end
    end

    // Operand resolution, hazard detection and source selection.
    always_comb begin
        rs1_val = resolve(rs1, rf_reg[rs1], fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data);
        rs2_val = resolve(rs2, rf_reg[rs2], fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data);
        rd0     = fwd_rd[RAW-1:0];
        hz      = in_valid & fwd_valid[0] & fwd_is_load & (rd0 != '0) &
                  ((rs1_used & (rs1 == rd0)) | (rs2_used & (rs2 == rd0)));
        advance = !out_valid || out_ready;
        in_ready = advance && !hz;
        case (src1_sel)
            2'd0:    src_a_next = rs1_val;
            2'd2:    src_a_next = in_pc;
            default: src_a_next = '0;
        endcase
        case (src2_sel)
            2'd0:    src_b_next = rs2_val;
            2'd1:    src_b_next = imm;
            2'd2:    src_b_next = XLEN'(4);
            default: src_b_next = '0;
        endcase
    end

    // Output pipeline register. Flush kills the held instruction even under
    // back-pressure; a bubble or flush never leaves out_rd_we set.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_ins      <= '0;
            out_src_a    <= '0;
            out_src_b    <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
            out_ctrl     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
        end else if (advance) begin
            if (hz) begin
                out_valid <= 1'b0;
                out_rd_we <= 1'b0;
            end else begin
                out_valid    <= in_valid;
                out_pc       <= in_pc;
                out_ins      <= in_ins;
                out_src_a    <= src_a_next;
                out_src_b    <= src_b_next;
                out_rs2_data <= rs2_val;
                out_rd       <= rd;
                out_rd_we    <= in_valid & rd_we;
                out_ctrl     <= ctrl_in;
            end
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hz && !flush && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef YSYX_22041071_RF_DUMP_EN
    // Flat view of the register file for difftest.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dump
        assign rf_dump[gi*XLEN +: XLEN] = rf_reg[gi];
    end
`else
    // No dump port in this build.
`endif

endmodule
